// File: rtl/spi_slave_cmd_parser.sv
// SPI slave front end: decodes addr/cmd/len frames into CSR writes, CSR reads and PSRAM byte writes.
// Optional CSR read path (command 2) is compiled in with `define SPI_SLAVE_CSR_READ_EN.
module spi_slave_cmd_parser #(
   parameter int pCsrAdrsWidth = 32,
   parameter int pPsAdrsWidth  = 19,
   parameter int pMaxLen       = 2048
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iSpiSck,
   input  logic                     iSpiMosi,
   input  logic                     iSpiCs,
   output logic                     oSpiMiso,
   output logic                     oSpiMisoEn,
   output logic [pCsrAdrsWidth-1:0] oCsrAdrs,
   output logic [31:0]              oCsrWd,
   output logic                     oCsrWe,
   output logic                     oCsrRe,
   input  logic [31:0]              iCsrRd,
   output logic [pPsAdrsWidth-1:0]  oPsAdrs,
   output logic [7:0]               oPsWd,
   output logic                     oPsVd,
   input  logic                     iPsRdy,
   output logic                     oErr,
   output logic                     oBusy
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CSR_WR,
`ifdef SPI_SLAVE_CSR_READ_EN
      CSR_RD_DMY,
      CSR_RD,
`endif
      PS_WR,
      DRAIN
   } state_t;

   state_t state;

   logic [1:0]  sckS, mosiS, csS;
   logic        sckD, csD;
   logic        sckRise, sckFall, csFall;
   logic [62:0] sh;
   logic [63:0] shNext;
   logic [6:0]  bitCnt;
   logic [15:0] lenCnt;
   logic [pPsAdrsWidth-1:0] psNext;
   logic [31:0] hdrAdr;
   logic [15:0] hdrCmd, hdrLen;

   assign sckRise = sckS[1] & ~sckD;
   assign sckFall = ~sckS[1] & sckD;
   assign csFall  = ~csS[1] & csD;
   assign shNext  = {sh, mosiS[1]};
   assign hdrAdr  = shNext[63:32];
   assign hdrCmd  = shNext[31:16];
   assign hdrLen  = shNext[15:0];

`ifdef SPI_SLAVE_CSR_READ_EN
   logic        csrReR, capPend, misoR, misoEnR;
   logic [31:0] rdSh;
   assign oCsrRe     = csrReR;
   assign oSpiMiso   = misoR;
   assign oSpiMisoEn = misoEnR;
`else
   logic unusedCsrRd;
   assign unusedCsrRd = ^iCsrRd;
   assign oCsrRe      = 1'b0;
   assign oSpiMiso    = 1'b1;
   assign oSpiMisoEn  = 1'b0;
`endif

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         sckS     <= 2'b00;
         mosiS    <= 2'b00;
         csS      <= 2'b11;
         sckD     <= 1'b0;
         csD      <= 1'b1;
         state    <= IDLE;
         sh       <= '0;
         bitCnt   <= '0;
         lenCnt   <= '0;
         psNext   <= '0;
         oCsrAdrs <= '0;
         oCsrWd   <= '0;
         oCsrWe   <= 1'b0;
         oPsAdrs  <= '0;
         oPsWd    <= '0;
         oPsVd    <= 1'b0;
         oErr     <= 1'b0;
         oBusy    <= 1'b0;
`ifdef SPI_SLAVE_CSR_READ_EN
         csrReR   <= 1'b0;
         capPend  <= 1'b0;
         misoR    <= 1'b1;
         misoEnR  <= 1'b0;
         rdSh     <= '0;
`endif
      end else begin
         sckS  <= {sckS[0], iSpiSck};
         mosiS <= {mosiS[0], iSpiMosi};
         csS   <= {csS[0], iSpiCs};
         sckD  <= sckS[1];
         csD   <= csS[1];
         oBusy <= ~csS[1];
         oCsrWe <= 1'b0;
         // A pending PSRAM byte survives CS aborts until the writer takes it.
         if (oPsVd && iPsRdy) oPsVd <= 1'b0;
`ifdef SPI_SLAVE_CSR_READ_EN
         csrReR  <= 1'b0;
         capPend <= csrReR;
         if (capPend) rdSh <= iCsrRd;
`endif
         if (csS[1]) begin
            state <= IDLE;
`ifdef SPI_SLAVE_CSR_READ_EN
            misoEnR <= 1'b0;
            misoR   <= 1'b1;
`endif
         end else begin
            case (state)
               IDLE: if (csFall) begin
                  state  <= HDR;
                  bitCnt <= '0;
                  oErr   <= 1'b0;
               end
               HDR: if (sckRise) begin
                  sh     <= shNext[62:0];
                  bitCnt <= bitCnt + 7'd1;
                  if (bitCnt == 7'd63) begin
                     bitCnt   <= '0;
                     oCsrAdrs <= hdrAdr[pCsrAdrsWidth-1:0];
                     psNext   <= hdrAdr[pPsAdrsWidth-1:0];
                     lenCnt   <= hdrLen;
                     if (hdrCmd == 16'd1 && hdrLen == 16'd4)
                        state <= CSR_WR;
`ifdef SPI_SLAVE_CSR_READ_EN
                     else if (hdrCmd == 16'd2 && hdrLen == 16'd4) begin
                        state  <= CSR_RD_DMY;
                        csrReR <= 1'b1;
                     end
`endif
                     else if (hdrCmd == 16'd3 && hdrLen != 16'd0 &&
                              {16'd0, hdrLen} <= 32'(pMaxLen))
                        state <= PS_WR;
                     else begin
                        state <= DRAIN;
                        if (hdrCmd != 16'd0) oErr <= 1'b1;
                     end
                  end
               end
               CSR_WR: if (sckRise) begin
                  sh     <= shNext[62:0];
                  bitCnt <= bitCnt + 7'd1;
                  if (bitCnt == 7'd31) begin
                     oCsrWd <= shNext[31:0];
                     oCsrWe <= 1'b1;
                     state  <= DRAIN;
                  end
               end
`ifdef SPI_SLAVE_CSR_READ_EN
               CSR_RD_DMY: if (sckRise) begin
                  bitCnt <= bitCnt + 7'd1;
                  if (bitCnt == 7'd7) begin
                     bitCnt  <= '0;
                     state   <= CSR_RD;
                     misoEnR <= 1'b1;
                     misoR   <= rdSh[31];
                  end
               end
               // The falling edge closing the last dummy bit must not advance,
               // so shifting starts only after the host has sampled bit 31.
               CSR_RD: if (sckRise) begin
                  bitCnt <= bitCnt + 7'd1;
                  if (bitCnt == 7'd31) begin
                     state   <= DRAIN;
                     misoEnR <= 1'b0;
                     misoR   <= 1'b1;
                  end
               end else if (sckFall && bitCnt != 7'd0) begin
                  rdSh  <= {rdSh[30:0], 1'b0};
                  misoR <= rdSh[30];
               end
`endif
               PS_WR: if (sckRise) begin
                  sh     <= shNext[62:0];
                  bitCnt <= bitCnt + 7'd1;
                  if (bitCnt == 7'd7) begin
                     bitCnt <= '0;
                     psNext <= psNext + 1'b1;
                     lenCnt <= lenCnt - 16'd1;
                     if (oPsVd && !iPsRdy)
                        oErr <= 1'b1;
                     else begin
                        oPsVd   <= 1'b1;
                        oPsWd   <= shNext[7:0];
                        oPsAdrs <= psNext;
                     end
                     if (lenCnt == 16'd1) state <= DRAIN;
                  end
               end
               DRAIN: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_cmd_parser.sv
// Scoreboard bench for spi_slave_cmd_parser: directed SPI frames, expected strobes queued, monitor compares.
module tb_spi_slave_cmd_parser;

   logic        iClk = 1'b0, iRst = 1'b1;
   logic        iSpiSck = 1'b0, iSpiMosi = 1'b0, iSpiCs = 1'b1;
   logic [31:0] iCsrRd = 32'hA5C3_0F81;
   logic        iPsRdy = 1'b1;
   logic        oSpiMiso, oSpiMisoEn, oCsrWe, oCsrRe, oPsVd, oErr, oBusy;
   logic [31:0] oCsrAdrs, oCsrWd;
   logic [18:0] oPsAdrs;
   logic [7:0]  oPsWd;

   spi_slave_cmd_parser dut (
      .iClk(iClk), .iRst(iRst), .iSpiSck(iSpiSck), .iSpiMosi(iSpiMosi), .iSpiCs(iSpiCs),
      .oSpiMiso(oSpiMiso), .oSpiMisoEn(oSpiMisoEn), .oCsrAdrs(oCsrAdrs), .oCsrWd(oCsrWd),
      .oCsrWe(oCsrWe), .oCsrRe(oCsrRe), .iCsrRd(iCsrRd), .oPsAdrs(oPsAdrs), .oPsWd(oPsWd),
      .oPsVd(oPsVd), .iPsRdy(iPsRdy), .oErr(oErr), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;

   int checks = 0, errors = 0;

   typedef struct {
      int          kind;   // 1 CSR write, 2 CSR read strobe, 3 PSRAM handshake
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;
   ev_t expQ[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic popChk(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event kind=%0d adrs=%h data=%h required=none", kind, a, d);
      end else begin
         e = expQ.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_adrs", a, e.a);
         chk("ev_data", d, e.d);
      end
   endtask

   always @(negedge iClk) if (!iRst) begin
      if (oCsrWe)          popChk(1, oCsrAdrs, oCsrWd);
      if (oCsrRe)          popChk(2, oCsrAdrs, 32'd0);
      if (oPsVd && iPsRdy) popChk(3, {13'd0, oPsAdrs}, {24'd0, oPsWd});
   end

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = kind; e.a = a; e.d = d;
      expQ.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge iClk); #1; end
   endtask

   task automatic xfer(input logic [31:0] w, input int n, output logic [31:0] r, output int en);
      r = '0; en = 0;
      for (int i = n - 1; i >= 0; i--) begin
         iSpiMosi = w[i];
         tick(5);
         iSpiSck = 1'b1;
         r = {r[30:0], oSpiMiso};
         en += int'(oSpiMisoEn);
         tick(5);
         iSpiSck = 1'b0;
      end
   endtask

   task automatic sendW(input logic [31:0] w);
      logic [31:0] r; int en;
      xfer(w, 32, r, en);
   endtask

   task automatic csLow();  iSpiCs = 1'b0; tick(6); endtask
   task automatic csHigh(); tick(4); iSpiCs = 1'b1; tick(8); endtask

   task automatic csrFrame(input logic [31:0] adr, input logic [31:0] data);
      csLow(); sendW(adr); sendW(32'h0001_0004); sendW(data); csHigh();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   logic [31:0] cmdTab [4] = '{32'h0000_0000, 32'h0005_0004, 32'h0003_0000, 32'h0003_0801};
   logic        errTab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      logic [31:0] r;
      int          en;
      tick(3);
      chk("rst_we", oCsrWe, 0);
      chk("rst_psvd", oPsVd, 0);
      chk("rst_err", oErr, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_miso", oSpiMiso, 1);
      chk("rst_misoen", oSpiMisoEn, 0);
      chk("rst_adrs", oCsrAdrs, 0);
      iRst = 1'b0;
      tick(5);

      // CSR write of zero
      push(1, 32'h0006_0000, 32'h0);
      csLow();
      chk("busy_low", oBusy, 1);
      sendW(32'h0006_0000); sendW(32'h0001_0004); sendW(32'h0);
      csHigh();
      chk("wr0_err", oErr, 0);
      chk("wr0_q", expQ.size(), 0);

      // two back-to-back CSR writes
      push(1, 32'h0004_0010, 32'h0000_000e);
      csrFrame(32'h0004_0010, 32'h0000_000e);
      push(1, 32'h0004_0010, 32'h0000_000c);
      csrFrame(32'h0004_0010, 32'h0000_000c);
      chk("wr2_q", expQ.size(), 0);
      chk("wr2_busy", oBusy, 0);

      // CSR read
`ifdef SPI_SLAVE_CSR_READ_EN
      push(2, 32'h0000_0020, 32'h0);
`endif
      csLow(); sendW(32'h0000_0020); sendW(32'h0002_0004);
      xfer(32'h0, 8, r, en);
      chk("rd_dmy_en", en, 0);
      xfer(32'h0, 32, r, en);
`ifdef SPI_SLAVE_CSR_READ_EN
      chk("rd_data", r, 32'hA5C3_0F81);
      chk("rd_en_cnt", en, 32);
      csHigh();
      chk("rd_err", oErr, 0);
`else
      chk("rd_data", r, 32'hFFFF_FFFF);
      chk("rd_en_cnt", en, 0);
      csHigh();
      chk("rd_err", oErr, 1);
`endif
      chk("rd_en_after", oSpiMisoEn, 0);
      chk("rd_q", expQ.size(), 0);

      // PSRAM write with address wrap
      push(3, 32'h7FFFE, 32'h11); push(3, 32'h7FFFF, 32'h22);
      push(3, 32'h00000, 32'h33); push(3, 32'h00001, 32'h44);
      csLow(); sendW(32'h0007_FFFE); sendW(32'h0003_0004); sendW(32'h1122_3344);
      csHigh();
      chk("ps_err", oErr, 0);
      chk("ps_q", expQ.size(), 0);

      // PSRAM writer stalled: first byte held, second dropped
      iPsRdy = 1'b0;
      csLow(); sendW(32'h0000_0100); sendW(32'h0003_0002);
      xfer(32'h0000_AABB, 16, r, en);
      csHigh();
      chk("stall_vd", oPsVd, 1);
      chk("stall_wd", oPsWd, 32'hAA);
      chk("stall_adrs", oPsAdrs, 32'h100);
      chk("stall_err", oErr, 1);
      push(3, 32'h100, 32'hAA);
      iPsRdy = 1'b1;
      tick(3);
      chk("stall_vd_done", oPsVd, 0);
      chk("stall_q", expQ.size(), 0);

      // CSR write with bad length
      csLow();
      chk("err_clr_csfall", oErr, 0);
      sendW(32'h0); sendW(32'h0001_0008); sendW(32'hDEAD_BEEF);
      csHigh();
      chk("badlen_err", oErr, 1);

      // abort after 16 data bits, then a clean frame
      csLow(); sendW(32'h0000_0044); sendW(32'h0001_0004);
      xfer(32'h0000_BEEF, 16, r, en);
      csHigh();
      chk("abort_err", oErr, 0);
      push(1, 32'h0000_0048, 32'h1234_5678);
      csrFrame(32'h0000_0048, 32'h1234_5678);
      chk("abort_q", expQ.size(), 0);

      // command/length decode table
      for (int i = 0; i < 4; i++) begin
         csLow(); sendW(32'h0000_0010); sendW(cmdTab[i]); csHigh();
         chk($sformatf("decode_err_%0d", i), oErr, errTab[i]);
      end

      // asynchronous reset mid-frame
      csLow(); sendW(32'h0000_0050);
      iRst = 1'b1;
      tick(2);
      chk("arst_busy", oBusy, 0);
      iSpiCs = 1'b1;
      iRst = 1'b0;
      tick(8);
      push(1, 32'h0000_0054, 32'hCAFE_F00D);
      csrFrame(32'h0000_0054, 32'hCAFE_F00D);
      chk("arst_q", expQ.size(), 0);

      tick(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
